// File: rtl/io_port_unit.sv
// io_port_unit: bidirectional general-purpose I/O port.
// Holds the port direction register and the output latch, synchronizes the
// external pins, and answers port reads on the memory bus with a frozen
// snapshot. It also flags input-pin changes and read/write strobe collisions.
module io_port_unit #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2   // legal range 2..4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic             PDR_EN,
    input  logic             PORT_EN,
    input  logic             PORT_RD,
    output logic [WIDTH-1:0] DATA_OUT,
    output logic             DATA_OE,
    input  logic [WIDTH-1:0] PIN_IN,
    output logic [WIDTH-1:0] PIN_OUT,
    output logic [WIDTH-1:0] PIN_OE,
    output logic             CHG,
    output logic             ERR
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRIVE   = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] pdr;
    logic [WIDTH-1:0] out_lat;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] snap;
    logic [WIDTH-1:0] rval;
    logic             chg_set;
    logic             read_start;

    assign sync = sync_q[SYNC_STAGES-1];

    // Output bits read back the latch; input bits read the synchronized pin.
    assign rval = (out_lat & pdr) | (sync & ~pdr);

    // Only input-direction bits may raise the change flag.
    assign chg_set = |((sync ^ prev) & ~pdr);

    // A read starts only on a clean cycle with no write strobe present.
    assign read_start = (state == IDLE) && PORT_RD && !PDR_EN && !PORT_EN;

    assign PIN_OUT = out_lat;
    assign PIN_OE  = pdr;

    // Pin synchronizer chain plus a one-cycle-delayed copy for edge detection.
    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: the stages are individual flops, not a RAM, so clearing
            // them on reset is cheap and keeps CHG quiet after reset.
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev <= '0;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the
            // previous stage's old value, which is what forms the chain.
            sync_q[0] <= PIN_IN;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev <= sync;
        end
    end

    // Direction and output latch loads; both may load the same word at once.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pdr     <= '0;
            out_lat <= '0;
        end else begin
            if (PDR_EN) begin
                pdr <= DATA_IN;
            end
            if (PORT_EN) begin
                out_lat <= DATA_IN;
            end
        end
    end

    // Read handshake FSM with registered bus outputs and the sticky flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            snap     <= '0;
            DATA_OUT <= '0;
            DATA_OE  <= 1'b0;
            CHG      <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            // A new change in the same cycle as the read start wins.
            CHG <= chg_set | (CHG & ~read_start);
            case (state)
                IDLE: begin
                    if (read_start) begin
                        snap  <= rval;
                        state <= CAPTURE;
                    end else if (PORT_RD) begin
                        ERR <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (PORT_RD) begin
                        state    <= DRIVE;
                        DATA_OE  <= 1'b1;
                        DATA_OUT <= snap;
                    end else begin
                        state <= IDLE;
                    end
                end
                DRIVE: begin
                    if (!PORT_RD) begin
                        state    <= IDLE;
                        DATA_OE  <= 1'b0;
                        DATA_OUT <= '0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    DATA_OE  <= 1'b0;
                    DATA_OUT <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_port_unit.sv
// tb_io_port_unit: directed scenarios plus randomized traffic for
// io_port_unit, checked against a cycle-level reference model of the port.
module tb_io_port_unit;

    localparam int W  = 8;
    localparam int SS = 2;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic [W-1:0] DATA_IN = '0;
    logic         PDR_EN = 1'b0;
    logic         PORT_EN = 1'b0;
    logic         PORT_RD = 1'b0;
    logic [W-1:0] PIN_IN = '0;
    logic [W-1:0] DATA_OUT;
    logic         DATA_OE;
    logic [W-1:0] PIN_OUT;
    logic [W-1:0] PIN_OE;
    logic         CHG;
    logic         ERR;

    int n_run  = 0;
    int n_fail = 0;

    io_port_unit #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .DATA_IN  (DATA_IN),
        .PDR_EN   (PDR_EN),
        .PORT_EN  (PORT_EN),
        .PORT_RD  (PORT_RD),
        .DATA_OUT (DATA_OUT),
        .DATA_OE  (DATA_OE),
        .PIN_IN   (PIN_IN),
        .PIN_OUT  (PIN_OUT),
        .PIN_OE   (PIN_OE),
        .CHG      (CHG),
        .ERR      (ERR)
    );

    always #5 CLK = ~CLK;

    // Reference model: port state described by its architectural meaning.
    logic [W-1:0] m_pdr, m_lat, m_prev, m_snap;
    logic [W-1:0] m_pins [$];   // pin samples; oldest entry is the synced value
    bit           m_chg, m_err;
    int           m_rd_age;     // edges PORT_RD has been held since capture

    task automatic model_edge();
        logic [W-1:0] sync, rval;
        bit           changed, start;
        if (RST) begin
            m_pdr = '0; m_lat = '0; m_prev = '0; m_snap = '0;
            m_chg = 0; m_err = 0; m_rd_age = 0;
            m_pins.delete();
            for (int i = 0; i < SS; i++) m_pins.push_back('0);
            return;
        end
        sync    = m_pins[0];
        rval    = (m_lat & m_pdr) | (sync & ~m_pdr);
        changed = ((sync ^ m_prev) & ~m_pdr) != 0;
        start   = (m_rd_age == 0) && PORT_RD && !PDR_EN && !PORT_EN;
        if (m_rd_age == 0) begin
            if (start) begin
                m_snap   = rval;
                m_rd_age = 1;
            end else if (PORT_RD) begin
                m_err = 1;
            end
        end else if (PORT_RD) begin
            m_rd_age = (m_rd_age < 2) ? m_rd_age + 1 : 2;
        end else begin
            m_rd_age = 0;
        end
        if (changed)    m_chg = 1;
        else if (start) m_chg = 0;
        if (PDR_EN)  m_pdr = DATA_IN;
        if (PORT_EN) m_lat = DATA_IN;
        m_prev = sync;
        m_pins.push_back(PIN_IN);
        void'(m_pins.pop_front());
    endtask

    // One clock: model follows the edge; returns at the falling edge.
    task automatic cycle();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RST = 1'b1; PDR_EN = 1'b1; PORT_EN = 1'b1; PORT_RD = 1'b1;
        DATA_IN = 8'hFF; PIN_IN = 8'hFF;
        cycle();
        cycle();
        n_run++; if (PIN_OUT !== 8'h00) begin n_fail++; $display("FAIL reset_pin_out: got %h expected 00", PIN_OUT); end
        n_run++; if (PIN_OE !== 8'h00) begin n_fail++; $display("FAIL reset_pin_oe: got %h expected 00", PIN_OE); end
        n_run++; if (DATA_OE !== 1'b0) begin n_fail++; $display("FAIL reset_data_oe: got %b expected 0", DATA_OE); end
        n_run++; if (CHG !== 1'b0) begin n_fail++; $display("FAIL reset_chg: got %b expected 0", CHG); end
        n_run++; if (ERR !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", ERR); end
        RST = 1'b0; PDR_EN = 1'b0; PORT_EN = 1'b0; PORT_RD = 1'b0;
        cycle();
    endtask

    task automatic test_write();
        PDR_EN = 1'b1; DATA_IN = 8'hF0;
        cycle();
        PDR_EN = 1'b0;
        n_run++; if (PIN_OE !== 8'hF0) begin n_fail++; $display("FAIL write_pdr: got %h expected f0", PIN_OE); end
        PORT_EN = 1'b1; DATA_IN = 8'hA5;
        cycle();
        PORT_EN = 1'b0;
        n_run++; if (PIN_OUT !== 8'hA5) begin n_fail++; $display("FAIL write_lat: got %h expected a5", PIN_OUT); end
        n_run++; if (PIN_OE !== 8'hF0) begin n_fail++; $display("FAIL write_pdr_kept: got %h expected f0", PIN_OE); end
    endtask

    task automatic test_mixed_read();
        PIN_IN = 8'h3C;
        repeat (SS + 1) cycle();
        PORT_RD = 1'b1;
        cycle();
        n_run++; if (DATA_OE !== 1'b0) begin n_fail++; $display("FAIL read_capture_oe: got %b expected 0", DATA_OE); end
        for (int k = 0; k < 2; k++) begin
            cycle();
            n_run++; if (DATA_OE !== 1'b1) begin n_fail++; $display("FAIL read_drive_oe: got %b expected 1", DATA_OE); end
            n_run++; if (DATA_OUT !== 8'hAC) begin n_fail++; $display("FAIL read_data: got %h expected ac", DATA_OUT); end
        end
        PORT_RD = 1'b0;
        cycle();
        n_run++; if (DATA_OE !== 1'b0) begin n_fail++; $display("FAIL read_end_oe: got %b expected 0", DATA_OE); end
        n_run++; if (DATA_OUT !== 8'h00) begin n_fail++; $display("FAIL read_end_data: got %h expected 00", DATA_OUT); end
    endtask

    task automatic test_change();
        PDR_EN = 1'b1; DATA_IN = 8'h00;
        cycle();
        PDR_EN = 1'b0;
        repeat (SS + 2) cycle();
        PORT_RD = 1'b1;
        cycle();
        PORT_RD = 1'b0;
        cycle();
        n_run++; if (CHG !== 1'b0) begin n_fail++; $display("FAIL chg_precleared: got %b expected 0", CHG); end
        PIN_IN = PIN_IN ^ 8'h01;
        for (int k = 1; k <= SS + 1; k++) begin
            cycle();
            n_run++;
            if (CHG !== (k == SS + 1)) begin
                n_fail++;
                $display("FAIL chg_latency edge %0d: got %b expected %b", k, CHG, (k == SS + 1));
            end
        end
        PORT_RD = 1'b1;
        cycle();
        n_run++; if (CHG !== 1'b0) begin n_fail++; $display("FAIL chg_read_clear: got %b expected 0", CHG); end
        repeat (2) cycle();
        PORT_RD = 1'b0;
        cycle();
        PDR_EN = 1'b1; DATA_IN = 8'h01;
        cycle();
        PDR_EN = 1'b0;
        PIN_IN = PIN_IN ^ 8'h01;
        for (int k = 1; k <= SS + 3; k++) begin
            cycle();
            n_run++; if (CHG !== 1'b0) begin n_fail++; $display("FAIL chg_output_bit edge %0d: got %b expected 0", k, CHG); end
        end
    endtask

    task automatic test_collision();
        PDR_EN = 1'b1; DATA_IN = 8'hF0; PIN_IN = 8'h3C;
        cycle();
        PDR_EN = 1'b0;
        repeat (SS + 2) cycle();
        PORT_RD = 1'b1; PORT_EN = 1'b1; DATA_IN = 8'h55;
        cycle();
        PORT_EN = 1'b0;
        n_run++; if (PIN_OUT !== 8'h55) begin n_fail++; $display("FAIL coll_pin_out: got %h expected 55", PIN_OUT); end
        n_run++; if (ERR !== 1'b1) begin n_fail++; $display("FAIL coll_err: got %b expected 1", ERR); end
        cycle();
        n_run++; if (DATA_OE !== 1'b0) begin n_fail++; $display("FAIL coll_no_early_drive: got %b expected 0", DATA_OE); end
        cycle();
        n_run++; if (DATA_OE !== 1'b1) begin n_fail++; $display("FAIL coll_retry_oe: got %b expected 1", DATA_OE); end
        n_run++; if (DATA_OUT !== 8'h5C) begin n_fail++; $display("FAIL coll_retry_data: got %h expected 5c", DATA_OUT); end
        PORT_RD = 1'b0;
        cycle();
    endtask

    task automatic test_freeze_and_reset();
        PORT_EN = 1'b1; DATA_IN = 8'hA5;
        cycle();
        PORT_EN = 1'b0;
        PORT_RD = 1'b1;
        repeat (2) cycle();
        n_run++; if (DATA_OUT !== 8'hAC) begin n_fail++; $display("FAIL freeze_start: got %h expected ac", DATA_OUT); end
        PIN_IN = 8'hC3;
        for (int k = 0; k < SS + 2; k++) begin
            cycle();
            n_run++; if (DATA_OUT !== 8'hAC) begin n_fail++; $display("FAIL freeze_hold: got %h expected ac", DATA_OUT); end
        end
        n_run++; if (ERR !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b expected 1", ERR); end
        RST = 1'b1;
        cycle();
        n_run++; if (DATA_OE !== 1'b0) begin n_fail++; $display("FAIL midrst_oe: got %b expected 0", DATA_OE); end
        n_run++; if (DATA_OUT !== 8'h00) begin n_fail++; $display("FAIL midrst_data: got %h expected 00", DATA_OUT); end
        n_run++; if (PIN_OUT !== 8'h00) begin n_fail++; $display("FAIL midrst_pin_out: got %h expected 00", PIN_OUT); end
        n_run++; if (PIN_OE !== 8'h00) begin n_fail++; $display("FAIL midrst_pin_oe: got %h expected 00", PIN_OE); end
        n_run++; if (ERR !== 1'b0) begin n_fail++; $display("FAIL midrst_err: got %b expected 0", ERR); end
        n_run++; if (CHG !== 1'b0) begin n_fail++; $display("FAIL midrst_chg: got %b expected 0", CHG); end
        RST = 1'b0; PORT_RD = 1'b0;
        cycle();
    endtask

    task automatic test_random();
        logic [W-1:0] exp_out;
        bit           exp_oe;
        for (int n = 0; n < 400; n++) begin
            RST     = ($urandom_range(63) == 0);
            PDR_EN  = ($urandom_range(7) == 0);
            PORT_EN = ($urandom_range(7) == 0);
            DATA_IN = W'($urandom);
            if ($urandom_range(3) == 0) PORT_RD = ~PORT_RD;
            if ($urandom_range(3) == 0) PIN_IN = W'($urandom);
            cycle();
            exp_oe  = (m_rd_age == 2);
            exp_out = exp_oe ? m_snap : '0;
            n_run++; if (PIN_OUT !== m_lat) begin n_fail++; $display("FAIL rnd_pin_out @%0d: got %h expected %h", n, PIN_OUT, m_lat); end
            n_run++; if (PIN_OE !== m_pdr) begin n_fail++; $display("FAIL rnd_pin_oe @%0d: got %h expected %h", n, PIN_OE, m_pdr); end
            n_run++; if (DATA_OE !== exp_oe) begin n_fail++; $display("FAIL rnd_data_oe @%0d: got %b expected %b", n, DATA_OE, exp_oe); end
            n_run++; if (DATA_OUT !== exp_out) begin n_fail++; $display("FAIL rnd_data_out @%0d: got %h expected %h", n, DATA_OUT, exp_out); end
            n_run++; if (CHG !== m_chg) begin n_fail++; $display("FAIL rnd_chg @%0d: got %b expected %b", n, CHG, m_chg); end
            n_run++; if (ERR !== m_err) begin n_fail++; $display("FAIL rnd_err @%0d: got %b expected %b", n, ERR, m_err); end
        end
        RST = 1'b0; PDR_EN = 1'b0; PORT_EN = 1'b0; PORT_RD = 1'b0;
        cycle();
    endtask

    initial begin
        m_rd_age = 0;
        test_reset();
        test_write();
        test_mixed_read();
        test_change();
        test_collision();
        test_freeze_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/io_port_unit.md
# io_port_unit

Bidirectional general-purpose I/O port for the RISC-Y processor. It is the responder for the I/O strobes issued by the sequence controller (PDR_EN, PORT_EN, PORT_RD):
- It holds the port direction register (PDR) and the output latch.
- It synchronizes the external pins and returns a snapshot on the memory bus during port reads.
- It flags input changes and protocol errors.

## Interface
Parameters:
- WIDTH, 8, port and bus data width
- SYNC_STAGES, 2, pin synchronizer depth (legal values 2–4)

Ports:
- CLK  in  1  system clock; all state changes on the rising edge
- RST  in  1  reset, synchronous, active-high
- DATA_IN  in  WIDTH  memory-bus value (immediate or RAM data) during load
- PDR_EN  in  1  load PDR from DATA_IN
- PORT_EN  in  1  load output latch from DATA_IN
- PORT_RD  in  1  port read request (level, held for the read)
- DATA_OUT  out  WIDTH  read data to memory bus
- DATA_OE  out  1  DATA_OUT valid and driving the bus
- PIN_IN  in  WIDTH  asynchronous external pin values
- PIN_OUT  out  WIDTH  output latch to the pads
- PIN_OE  out  WIDTH  per-bit pad enable (= PDR; 1 = output)
- CHG  out  1  sticky: an input-direction pin changed since the last read
- ERR  out  1  sticky: PORT_RD collided with PDR_EN or PORT_EN

## Operation
**Registers.** PDR[WIDTH], OUT_LAT[WIDTH], an SYNC_STAGES-deep synchronizer chain producing SYNC[WIDTH], PREV[WIDTH] (SYNC delayed one cycle), SNAP[WIDTH], CHG, ERR, and the FSM state.

**Writes.**
- PDR_EN=1 → PDR <= DATA_IN.
- PORT_EN=1 → OUT_LAT <= DATA_IN.
- Both asserted in the same cycle → both registers load the same DATA_IN.

**Outputs.** PIN_OUT = OUT_LAT and PIN_OE = PDR, both direct register outputs.

**Read value.** RVAL = (OUT_LAT & PDR) | (SYNC & ~PDR). Output bits read back the latch; input bits read the synchronized pin.

**FSM** (IDLE, CAPTURE, DRIVE):
- IDLE: if PORT_RD=1, PDR_EN=0 and PORT_EN=0 → SNAP <= RVAL, go to CAPTURE.
- IDLE: if PORT_RD=1 together with PDR_EN or PORT_EN → write executes, ERR <= 1, stay in IDLE. The read is dropped; it restarts on the first clean cycle while PORT_RD is still high.
- CAPTURE: PORT_RD=1 → DRIVE; PORT_RD=0 → IDLE (aborted read, no bus drive).
- DRIVE: hold while PORT_RD=1; go to IDLE on PORT_RD=0.
- DATA_OE=1 only in DRIVE. DATA_OUT = SNAP in DRIVE, all zeros otherwise.
- SNAP is frozen for the whole read. Pin changes during DRIVE do not alter DATA_OUT.

**Change detect.**
- CHG <= 1 when ((SYNC ^ PREV) & ~PDR) != 0.
- CHG is cleared on the IDLE→CAPTURE transition.
- If set and clear conditions occur in the same cycle, set wins.
- Changes on output-direction bits never set CHG.

**ERR** is cleared only by RST.

**Reset.** RST=1 at an edge (including mid-read) forces:
- PDR=0 (all inputs), OUT_LAT=0, SNAP=0, CHG=0, ERR=0, state IDLE.
- Synchronizer stages and PREV reset to 0.

Hence after reset: PIN_OUT=0, PIN_OE=0, DATA_OUT=0, DATA_OE=0. RST overrides every strobe.

## Timing
- Write latency: strobe high at edge N → PIN_OUT/PIN_OE take the new value after edge N. Exactly one load per high cycle; a multi-cycle strobe reloads each cycle.
- Pin latency: a PIN_IN change before edge N appears in SYNC after edge N+SYNC_STAGES−1. CHG sets one edge later.
- Read latency: PORT_RD rises before edge N:
  - SNAP captured and state = CAPTURE after edge N.
  - DATA_OE=1 after edge N+1.
  - DATA_OE=0 after the first edge that samples PORT_RD=0.
- A controller read phase of ≥2 cycles yields valid bus data from the second cycle on.
- Back-to-back reads need PORT_RD low for at least one sampled edge between them.
- No combinational path from any input to any output.

## Test plan
1. **Reset:** drive RST for 2 cycles with all strobes and PIN_IN=FF → PIN_OUT=00, PIN_OE=00, DATA_OE=0, CHG=0, ERR=0.
2. **Write:**
   - PDR_EN with DATA_IN=F0 → PIN_OE=F0 after that edge.
   - PORT_EN with DATA_IN=A5 → PIN_OUT=A5 after that edge.
3. **Mixed read:** PDR=F0, OUT_LAT=A5, PIN_IN=3C held ≥SYNC_STAGES+1 cycles; PORT_RD high for 3 cycles → DATA_OE high for 2 cycles, DATA_OUT=AC; DATA_OE drops the cycle after PORT_RD falls.
4. **Change flag:**
   - PDR=00, toggle PIN_IN bit 0 → CHG=1 at edge SYNC_STAGES+1.
   - A subsequent read clears CHG.
   - Toggling a pin whose PDR bit is 1 leaves CHG at 0.
5. **Collision:** PORT_RD and PORT_EN (DATA_IN=55) in the same cycle → PIN_OUT=55, ERR=1, state stays IDLE for that cycle. Read proceeds next cycle with DATA_OUT reflecting 55 on output bits.
6. **Mid-read reset and freeze:**
   - Assert RST while in DRIVE → DATA_OE=0 and state IDLE after that edge, all registers zero.
   - Separately, change PIN_IN during DRIVE → DATA_OUT unchanged.
